// File: rtl/lms_ctr_flash_rd_seq.sv
// Flash READ sequencer: drives an 8-bit SPI master core's register port to
// issue opcode + address + dummy bytes and streams the captured bytes out.
module lms_ctr_flash_rd_seq #(
    parameter logic [7:0] CMD_OPCODE = 8'h03,
    parameter int         ADDR_BYTES = 3,
    parameter int         LEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      flash_addr,
    input  logic [LEN_W-1:0] rd_len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             spi_select,
    output logic [2:0]       mem_addr,
    output logic             write_n,
    output logic             read_n,
    output logic [15:0]      data_from_cpu,
    input  logic [15:0]      data_to_cpu,
    input  logic             dataavailable,
    input  logic             readyfordata
);

    localparam int HDR_W = 8 * (ADDR_BYTES + 1);

    typedef enum logic [3:0] {
        IDLE, SS_SEL, SSO_ON, HDR_WR, HDR_WAIT, HDR_RD,
        DAT_WR, DAT_WAIT, DAT_RD, OUT, SSO_OFF, DONE
    } state_t;

    state_t state, state_n;
    state_t acc_next;

    // Access phase: 0 = bus released (doubles as the gap between accesses),
    // 1 and 2 = the two strobe cycles of one register access.
    logic [1:0]       ph, ph_n;
    logic [HDR_W-1:0] hdr_q;
    logic [2:0]       hdr_left;
    logic [LEN_W-1:0] cnt;

    logic        acc_wr, acc_rd, acc_gate, acc_on;
    logic [2:0]  acc_addr;
    logic [15:0] acc_data;
    logic        unused_bits;

    assign unused_bits = ^{data_to_cpu[15:8], flash_addr};

    // State and access-phase registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ph    <= 2'd0;
        end else begin
            state <= state_n;
            ph    <= ph_n;
        end
    end

    // Next-state logic plus selection of which register access each state performs
    always_comb begin
        state_n  = state;
        ph_n     = ph;
        acc_wr   = 1'b0;
        acc_rd   = 1'b0;
        acc_gate = 1'b1;
        acc_addr = 3'd0;
        acc_data = 16'h0000;
        acc_next = state;
        unique case (state)
            IDLE: begin
                if (start) state_n = (rd_len != '0) ? SS_SEL : DONE;
            end
            SS_SEL: begin
                acc_wr   = 1'b1;
                acc_addr = 3'd5;
                acc_data = 16'h0001;
                acc_next = SSO_ON;
            end
            SSO_ON: begin
                acc_wr   = 1'b1;
                acc_addr = 3'd3;
                acc_data = 16'h0400;
                acc_next = HDR_WR;
            end
            HDR_WR: begin
                acc_wr   = 1'b1;
                acc_gate = readyfordata;
                acc_addr = 3'd1;
                acc_data = {8'h00, hdr_q[HDR_W-1 -: 8]};
                acc_next = HDR_WAIT;
            end
            HDR_WAIT: begin
                if (dataavailable) state_n = HDR_RD;
            end
            HDR_RD: begin
                acc_rd   = 1'b1;
                acc_next = (hdr_left == 3'd1) ? DAT_WR : HDR_WR;
            end
            DAT_WR: begin
                acc_wr   = 1'b1;
                acc_gate = readyfordata;
                acc_addr = 3'd1;
                acc_next = DAT_WAIT;
            end
            DAT_WAIT: begin
                if (dataavailable) state_n = DAT_RD;
            end
            DAT_RD: begin
                acc_rd   = 1'b1;
                acc_next = OUT;
            end
            OUT: begin
                if (rd_ready) state_n = (cnt == LEN_W'(1)) ? SSO_OFF : DAT_WR;
            end
            SSO_OFF: begin
                acc_wr   = 1'b1;
                acc_addr = 3'd3;
                acc_next = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (acc_wr || acc_rd) begin
            case (ph)
                2'd0: if (acc_gate) ph_n = 2'd1;
                2'd1: ph_n = 2'd2;
                default: begin
                    ph_n    = 2'd0;
                    state_n = acc_next;
                end
            endcase
        end
    end

    assign acc_on        = (acc_wr || acc_rd) && (ph != 2'd0);
    assign spi_select    = acc_on;
    assign write_n       = !(acc_on && acc_wr);
    assign read_n        = !(acc_on && acc_rd);
    assign mem_addr      = acc_on ? acc_addr : 3'd0;
    assign data_from_cpu = (acc_on && acc_wr) ? acc_data : 16'h0000;
    assign busy          = (state != IDLE) && (state != DONE);
    assign done          = (state == DONE);
    assign rd_valid      = (state == OUT);

    // Command latch, header shifter, remaining-byte counter and received byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_q    <= '0;
            hdr_left <= 3'd0;
            cnt      <= '0;
            rd_data  <= 8'h00;
        end else begin
            if (state == IDLE && start && rd_len != '0) begin
                hdr_q    <= {CMD_OPCODE, flash_addr[8*ADDR_BYTES-1:0]};
                hdr_left <= 3'(ADDR_BYTES + 1);
                cnt      <= rd_len;
            end
            if (state == HDR_RD && ph == 2'd2) begin
                hdr_q    <= hdr_q << 8;
                hdr_left <= hdr_left - 3'd1;
            end
            if (state == DAT_RD && ph == 2'd2) begin
                rd_data <= data_to_cpu[7:0];
            end
            if (state == OUT && rd_ready) begin
                cnt <= cnt - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lms_ctr_flash_rd_seq.sv
// Bench for the flash read sequencer with a behavioural SPI core register model.
module tb_lms_ctr_flash_rd_seq;

    localparam int ADDR_BYTES = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] flash_addr = 32'h0;
    logic [15:0] rd_len = 16'h0;
    logic        busy, done, rd_valid;
    logic [7:0]  rd_data;
    logic        rd_ready = 1'b0;
    logic        spi_select, write_n, read_n;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu = 16'hFFFF;
    logic        dataavailable = 1'b0;
    logic        readyfordata = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    logic [18:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  data_base = 8'h00;
    int          seq_base = 0;

    int          run = 0;
    logic [2:0]  a0;
    logic [15:0] d0;
    logic [1:0]  s0;
    int wr_count = 0, reg1_count = 0, done_count = 0;
    int busy_cycles = 0, select_cycles = 0, da_timer = 0, seq;
    logic [7:0]  rx_byte = 8'hEE;

    lms_ctr_flash_rd_seq #(
        .CMD_OPCODE(8'h03),
        .ADDR_BYTES(ADDR_BYTES),
        .LEN_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .flash_addr(flash_addr),
        .rd_len(rd_len),
        .busy(busy),
        .done(done),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .spi_select(spi_select),
        .mem_addr(mem_addr),
        .write_n(write_n),
        .read_n(read_n),
        .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu),
        .dataavailable(dataavailable),
        .readyfordata(readyfordata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] len, input logic [7:0] base);
        if (len != 16'd0) begin
            wr_q.push_back({3'd5, 16'h0001});
            wr_q.push_back({3'd3, 16'h0400});
            wr_q.push_back({3'd1, 16'h0003});
            for (int i = ADDR_BYTES - 1; i >= 0; i--) wr_q.push_back({3'd1, 8'h00, addr[8*i +: 8]});
            for (int i = 0; i < int'(len); i++) begin
                wr_q.push_back({3'd1, 16'h0000});
                rd_q.push_back(base + 8'(i));
            end
            wr_q.push_back({3'd3, 16'h0000});
        end
        data_base = base;
        seq_base  = reg1_count;
        @(posedge clk); #1;
        flash_addr = addr;
        rd_len     = len;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < budget);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    // SPI core model, access-timing monitor and output scoreboard
    initial forever begin
        @(negedge clk);
        if (reset) begin
            run = 0;
            da_timer = 0;
            dataavailable = 1'b0;
            data_to_cpu = 16'hFFFF;
        end else begin
            if (busy) busy_cycles++;
            if (spi_select) select_cycles++;
            if (done) done_count++;
            if (da_timer > 0) begin
                da_timer--;
                if (da_timer == 0) dataavailable = 1'b1;
            end
            if (spi_select) begin
                checkOutput("one_strobe", 32'(write_n ^ read_n), 32'd1);
                if (run == 0) begin
                    a0 = mem_addr;
                    d0 = data_from_cpu;
                    s0 = {write_n, read_n};
                end else begin
                    checkOutput("addr_stable", 32'(mem_addr), 32'(a0));
                    checkOutput("data_stable", 32'(data_from_cpu), 32'(d0));
                    checkOutput("strobe_stable", 32'({write_n, read_n}), 32'(s0));
                end
                run++;
                if (run == 2) begin
                    if (!write_n) begin
                        wr_count++;
                        checkOutput("write_expected", 32'(wr_q.size() > 0), 32'd1);
                        if (wr_q.size() > 0) checkOutput("bus_write", 32'({mem_addr, data_from_cpu}), 32'(wr_q.pop_front()));
                        if (mem_addr == 3'd1) begin
                            seq = reg1_count - seq_base;
                            rx_byte = (seq > ADDR_BYTES) ? data_base + 8'(seq - ADDR_BYTES - 1) : 8'hEE;
                            reg1_count++;
                            da_timer = 3;
                        end
                    end else begin
                        checkOutput("read_addr", 32'(mem_addr), 32'd0);
                        data_to_cpu = {8'h5A, rx_byte};
                        dataavailable = 1'b0;
                    end
                end
            end else begin
                checkOutput("idle_strobes", 32'({write_n, read_n}), 32'(2'b11));
                if (run != 0) checkOutput("access_len", 32'(run), 32'd2);
                run = 0;
                data_to_cpu = 16'hFFFF;
            end
            if (rd_valid && rd_ready) begin
                checkOutput("rd_expected", 32'(rd_q.size() > 0), 32'd1);
                if (rd_q.size() > 0) checkOutput("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
            end
        end
    end

    // Directed test sequence
    initial begin
        int snap_done, snap_busy, snap_sel, snap_r1, snap_wr, k;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
        checkOutput("rst_select", 32'(spi_select), 32'd0);
        checkOutput("rst_write_n", 32'(write_n), 32'd1);
        checkOutput("rst_read_n", 32'(read_n), 32'd1);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_wdata", 32'(data_from_cpu), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] basic 4-byte read");
        rd_ready = 1'b1;
        snap_done = done_count;
        applyStimulus(32'h00123456, 16'd4, 8'hA0);
        @(negedge clk);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        waitDone("basic", 2000);
        repeat (2) @(negedge clk);
        checkOutput("basic_wr_left", 32'(wr_q.size()), 32'd0);
        checkOutput("basic_rd_left", 32'(rd_q.size()), 32'd0);
        checkOutput("basic_done_pulses", 32'(done_count - snap_done), 32'd1);

        $display("[TB] zero-length read");
        snap_done = done_count;
        snap_busy = busy_cycles;
        snap_sel  = select_cycles;
        applyStimulus(32'h00001234, 16'd0, 8'h00);
        @(negedge clk);
        checkOutput("zero_done", 32'(done), 32'd1);
        checkOutput("zero_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("zero_done_pulses", 32'(done_count - snap_done), 32'd1);
        checkOutput("zero_busy_cycles", 32'(busy_cycles - snap_busy), 32'd0);
        checkOutput("zero_select_cycles", 32'(select_cycles - snap_sel), 32'd0);

        $display("[TB] consumer backpressure");
        rd_ready = 1'b0;
        applyStimulus(32'h00000100, 16'd3, 8'h10);
        for (int b = 0; b < 3; b++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!rd_valid && k < 500);
            checkOutput("bp_valid_seen", 32'(rd_valid), 32'd1);
            if (b == 1) begin
                snap_r1 = reg1_count;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    checkOutput("bp_hold_valid", 32'(rd_valid), 32'd1);
                    checkOutput("bp_hold_data", 32'(rd_data), 32'(rd_q.size() > 0 ? rd_q[0] : 8'h00));
                end
                checkOutput("bp_no_reg1", 32'(reg1_count - snap_r1), 32'd0);
            end
            @(posedge clk); #1;
            rd_ready = 1'b1;
            @(posedge clk); #1;
            rd_ready = 1'b0;
        end
        waitDone("bp", 2000);
        checkOutput("bp_rd_left", 32'(rd_q.size()), 32'd0);

        $display("[TB] transmitter stall and ignored start");
        rd_ready = 1'b1;
        readyfordata = 1'b0;
        snap_wr = wr_count;
        snap_r1 = reg1_count;
        snap_done = done_count;
        applyStimulus(32'h00FEDCBA, 16'd2, 8'h60);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (wr_count < snap_wr + 2 && k < 200);
        checkOutput("stall_setup_writes", 32'(wr_count - snap_wr), 32'd2);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        flash_addr = 32'h00000000;
        rd_len = 16'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("stall_no_reg1", 32'(reg1_count - snap_r1), 32'd0);
        checkOutput("stall_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        readyfordata = 1'b1;
        waitDone("stall", 2000);
        repeat (3) @(negedge clk);
        checkOutput("stall_wr_left", 32'(wr_q.size()), 32'd0);
        checkOutput("stall_rd_left", 32'(rd_q.size()), 32'd0);
        checkOutput("stall_done_pulses", 32'(done_count - snap_done), 32'd1);

        $display("[TB] reset during data wait");
        snap_r1 = reg1_count;
        applyStimulus(32'h00000010, 16'd3, 8'h40);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (reg1_count < snap_r1 + 5 && k < 500);
        checkOutput("rst_mid_reached", 32'(reg1_count - snap_r1), 32'd5);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_write_n", 32'(write_n), 32'd1);
        checkOutput("rst_mid_read_n", 32'(read_n), 32'd1);
        checkOutput("rst_mid_select", 32'(spi_select), 32'd0);
        checkOutput("rst_mid_valid", 32'(rd_valid), 32'd0);
        wr_q.delete();
        rd_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] read after reset");
        snap_done = done_count;
        applyStimulus(32'h00ABCDEF, 16'd2, 8'h30);
        waitDone("post_rst", 2000);
        repeat (2) @(negedge clk);
        checkOutput("post_rst_wr_left", 32'(wr_q.size()), 32'd0);
        checkOutput("post_rst_rd_left", 32'(rd_q.size()), 32'd0);
        checkOutput("post_rst_done_pulses", 32'(done_count - snap_done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
